// File: rtl/id_decode_stage.sv
// MIPS ID stage: IF/ID reg, regfile with write-through bypass, decoder, load-use detect, ID/EX reg.
// Latency 2 edges F->E; load-use stalls F/IF-ID one cycle (bubble to E); pc_src_M flushes both registers.
module id_decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction_F,
    input  logic [31:0] pc_plus_4_F,
    input  logic        pc_src_M,
    input  logic        reg_write_W,
    input  logic [4:0]  write_reg_W,
    input  logic [31:0] result_W,
    output logic        stall_F,
    output logic        reg_write_E,
    output logic        mem_to_reg_E,
    output logic        mem_write_E,
    output logic        branch_E,
    output logic        bne_E,
    output logic        alu_src_E,
    output logic        reg_dst_E,
    output logic [3:0]  alu_ctrl_E,
    output logic [31:0] rd1_E,
    output logic [31:0] rd2_E,
    output logic [31:0] imm_E,
    output logic [31:0] pc_plus_4_E,
    output logic [4:0]  rs_E,
    output logic [4:0]  rt_E,
    output logic [4:0]  rd_E,
    output logic [4:0]  shamt_E
);
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_LUI = 4'd7;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic        branch;
        logic        bne;
        logic        alu_src;
        logic        reg_dst;
        logic [3:0]  alu_ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
    } idex_t;

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    idex_t       idex_q, idex_d, dec;

    logic [5:0]  opcode_D, funct_D;
    logic [4:0]  rs_D, rt_D;
    logic [31:0] rd1_D, rd2_D;

    assign opcode_D = instr_q[31:26];
    assign funct_D  = instr_q[5:0];
    assign rs_D     = instr_q[25:21];
    assign rt_D     = instr_q[20:16];

    // Same-cycle write-back wins over the array so a W->D dependency needs no extra stall.
    assign rd1_D = (rs_D == 5'd0) ? 32'd0 :
                   (reg_write_W && write_reg_W == rs_D) ? result_W : regs_q[rs_D];
    assign rd2_D = (rt_D == 5'd0) ? 32'd0 :
                   (reg_write_W && write_reg_W == rt_D) ? result_W : regs_q[rt_D];

    assign stall_F = idex_q.mem_to_reg && (idex_q.rt != 5'd0) &&
                     ((idex_q.rt == rs_D) || (idex_q.rt == rt_D));

    always_comb begin
        dec       = '0;
        dec.rd1   = rd1_D;
        dec.rd2   = rd2_D;
        dec.pc4   = pc4_q;
        dec.rs    = rs_D;
        dec.rt    = rt_D;
        dec.rd    = instr_q[15:11];
        dec.shamt = instr_q[10:6];
        dec.imm   = {{16{instr_q[15]}}, instr_q[15:0]};
        case (opcode_D)
            6'h00: begin
                dec.reg_write = 1'b1;
                dec.reg_dst   = 1'b1;
                case (funct_D)
                    6'h20:   dec.alu_ctrl = ALU_ADD;
                    6'h22:   dec.alu_ctrl = ALU_SUB;
                    6'h24:   dec.alu_ctrl = ALU_AND;
                    6'h25:   dec.alu_ctrl = ALU_OR;
                    6'h2A:   dec.alu_ctrl = ALU_SLT;
                    6'h00:   dec.alu_ctrl = ALU_SLL;
                    6'h02:   dec.alu_ctrl = ALU_SRL;
                    default: begin
                        dec.reg_write = 1'b0;
                        dec.reg_dst   = 1'b0;
                    end
                endcase
            end
            6'h08: begin
                dec.alu_ctrl = ALU_ADD; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
            end
            6'h0C: begin
                dec.alu_ctrl = ALU_AND; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.imm = {16'h0, instr_q[15:0]};
            end
            6'h0D: begin
                dec.alu_ctrl = ALU_OR; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.imm = {16'h0, instr_q[15:0]};
            end
            6'h0F: begin
                dec.alu_ctrl = ALU_LUI; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.imm = {instr_q[15:0], 16'h0};
            end
            6'h23: begin
                dec.alu_ctrl = ALU_ADD; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.mem_to_reg = 1'b1;
            end
            6'h2B: begin
                dec.alu_ctrl = ALU_ADD; dec.alu_src = 1'b1; dec.mem_write = 1'b1;
            end
            6'h04: begin
                dec.alu_ctrl = ALU_SUB; dec.branch = 1'b1;
            end
            6'h05: begin
                dec.alu_ctrl = ALU_SUB; dec.branch = 1'b1; dec.bne = 1'b1;
            end
            default: ;
        endcase
    end

    // Flush outranks stall: a redirected stream must not keep the held instruction.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        if (pc_src_M) begin
            instr_d = '0;
            pc4_d   = '0;
        end else if (!stall_F) begin
            instr_d = instruction_F;
            pc4_d   = pc_plus_4_F;
        end
        idex_d = (pc_src_M || stall_F) ? '0 : dec;
    end

    always_comb begin
        regs_d = regs_q;
        if (reg_write_W && write_reg_W != 5'd0) regs_d[write_reg_W] = result_W;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= '0;
            pc4_q   <= '0;
            idex_q  <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            idex_q  <= idex_d;
            regs_q  <= regs_d;
        end
    end

    assign reg_write_E  = idex_q.reg_write;
    assign mem_to_reg_E = idex_q.mem_to_reg;
    assign mem_write_E  = idex_q.mem_write;
    assign branch_E     = idex_q.branch;
    assign bne_E        = idex_q.bne;
    assign alu_src_E    = idex_q.alu_src;
    assign reg_dst_E    = idex_q.reg_dst;
    assign alu_ctrl_E   = idex_q.alu_ctrl;
    assign rd1_E        = idex_q.rd1;
    assign rd2_E        = idex_q.rd2;
    assign imm_E        = idex_q.imm;
    assign pc_plus_4_E  = idex_q.pc4;
    assign rs_E         = idex_q.rs;
    assign rt_E         = idex_q.rt;
    assign rd_E         = idex_q.rd;
    assign shamt_E      = idex_q.shamt;
endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: expected E-stage snapshots are queued per edge and checked by a monitor.
module tb_id_decode_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction_F, pc_plus_4_F, result_W;
    logic        pc_src_M, reg_write_W;
    logic [4:0]  write_reg_W;
    logic        stall_F, reg_write_E, mem_to_reg_E, mem_write_E, branch_E, bne_E, alu_src_E, reg_dst_E;
    logic [3:0]  alu_ctrl_E;
    logic [31:0] rd1_E, rd2_E, imm_E, pc_plus_4_E;
    logic [4:0]  rs_E, rt_E, rd_E, shamt_E;

    id_decode_stage dut (
        .clk(clk), .reset(reset), .instruction_F(instruction_F), .pc_plus_4_F(pc_plus_4_F),
        .pc_src_M(pc_src_M), .reg_write_W(reg_write_W), .write_reg_W(write_reg_W), .result_W(result_W),
        .stall_F(stall_F), .reg_write_E(reg_write_E), .mem_to_reg_E(mem_to_reg_E),
        .mem_write_E(mem_write_E), .branch_E(branch_E), .bne_E(bne_E), .alu_src_E(alu_src_E),
        .reg_dst_E(reg_dst_E), .alu_ctrl_E(alu_ctrl_E), .rd1_E(rd1_E), .rd2_E(rd2_E), .imm_E(imm_E),
        .pc_plus_4_E(pc_plus_4_E), .rs_E(rs_E), .rt_E(rt_E), .rd_E(rd_E), .shamt_E(shamt_E)
    );

    always #5 clk = ~clk;

    // ctrl = {reg_write, mem_to_reg, mem_write, branch, bne, alu_src, reg_dst, alu_ctrl[3:0]}
    typedef struct packed {
        logic [10:0] ctrl;
        logic [31:0] rd1, rd2, imm, pc4;
        logic [4:0]  rs, rt, rd, shamt;
        logic        stall;
    } obs_t;

    typedef struct {
        int    e;
        obs_t  v;
        obs_t  m;
        string name;
    } rec_t;

    localparam logic [10:0] C_ADDI = 11'b1_0_0_0_0_1_0_0000;
    localparam logic [10:0] C_ORI  = 11'b1_0_0_0_0_1_0_0011;
    localparam logic [10:0] C_ADD  = 11'b1_0_0_0_0_0_1_0000;
    localparam logic [10:0] C_LW   = 11'b1_1_0_0_0_1_0_0000;

    localparam logic [31:0] I_ADDI5 = 32'h2005FFFC;
    localparam logic [31:0] I_ORI5  = 32'h3405FFFF;
    localparam logic [31:0] I_ADDI6 = 32'h20060007;
    localparam logic [31:0] I_LW2   = 32'h8C220000;
    localparam logic [31:0] I_LW0   = 32'h8C200000;
    localparam logic [31:0] I_ADD3  = 32'h00441820;
    localparam logic [31:0] I_ADD30 = 32'h00001820;
    localparam logic [31:0] I_SW    = 32'hAC080004;

    rec_t q[$];
    int   edges = 0;
    int   checks = 0;
    int   errors = 0;
    obs_t act;

    always @(posedge clk) edges <= edges + 1;

    assign act = '{ctrl: {reg_write_E, mem_to_reg_E, mem_write_E, branch_E, bne_E, alu_src_E,
                          reg_dst_E, alu_ctrl_E},
                   rd1: rd1_E, rd2: rd2_E, imm: imm_E, pc4: pc_plus_4_E,
                   rs: rs_E, rt: rt_E, rd: rd_E, shamt: shamt_E, stall: stall_F};

    function automatic obs_t mk(input logic [10:0] c, input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] im, input logic [31:0] p, input logic [4:0] s,
                                input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                                input logic st);
        obs_t o;
        o = '{ctrl: c, rd1: r1, rd2: r2, imm: im, pc4: p, rs: s, rt: t, rd: d, shamt: sh, stall: st};
        return o;
    endfunction

    task automatic expect_at(input int e, input string n, input obs_t v, input obs_t m);
        rec_t r;
        r.e = e; r.v = v; r.m = m; r.name = n;
        q.push_back(r);
    endtask

    task automatic expect_full(input int e, input string n, input obs_t v);
        expect_at(e, n, v, '1);
    endtask

    // Decoded all-zero instruction from a flushed IF/ID: only the side-effect-free view is pinned.
    task automatic expect_nop(input int e, input string n);
        expect_at(e, n, '0, mk(11'b0_1_1_1_1_1_0_0000, '1, '1, '1, '1, '1, '1, '1, '1, 1'b1));
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].e < edges) begin
            checks++; errors++;
            $display("FAIL %s: expectation for edge %0d never sampled (now %0d)", q[0].name, q[0].e, edges);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].e == edges) begin
            rec_t r;
            r = q.pop_front();
            checks++;
            if ((act & r.m) !== (r.v & r.m)) begin
                errors++;
                $display("FAIL %s @edge %0d: got %h expected %h (mask %h)", r.name, edges, act, r.v, r.m);
            end
        end
    end

    task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic ps,
                        input logic we, input logic [4:0] wr, input logic [31:0] wd);
        instruction_F = ins; pc_plus_4_F = pc; pc_src_M = ps;
        reg_write_W = we; write_reg_W = wr; result_W = wd;
        @(posedge clk); #1;
    endtask

    initial begin
        int b;
        reset = 1'b0;
        instruction_F = '0; pc_plus_4_F = '0; pc_src_M = 1'b0;
        reg_write_W = 1'b0; write_reg_W = '0; result_W = '0;
        expect_full(1, "reset_e1", '0);
        expect_full(2, "reset_e2", '0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        b = edges;
        expect_full(b + 2, "addi_sext", mk(C_ADDI, 0, 0, 32'hFFFFFFFC, 32'h104, 0, 5, 31, 31, 0));
        expect_full(b + 3, "ori_zext", mk(C_ORI, 0, 0, 32'h0000FFFF, 32'h108, 0, 5, 31, 31, 0));
        step(I_ADDI5, 32'h104, 0, 0, 0, 0);
        step(I_ORI5, 32'h108, 0, 0, 0, 0);
        step(0, 32'h10C, 0, 0, 0, 0);

        b = edges;
        expect_full(b + 2, "wb_bypass", mk(C_ADD, 32'h12345678, 32'h12345678, 32'h4820, 32'h110, 8, 8, 9, 0, 0));
        expect_full(b + 3, "wr0_bypass", mk(C_ADD, 0, 32'h12345678, 32'h5020, 32'h114, 0, 8, 10, 0, 0));
        expect_full(b + 4, "wr0_array", mk(C_ADD, 0, 0, 32'h5820, 32'h118, 0, 0, 11, 0, 0));
        step(32'h01084820, 32'h110, 0, 0, 0, 0);
        step(32'h00085020, 32'h114, 0, 1, 8, 32'h12345678);
        step(32'h00005820, 32'h118, 0, 1, 0, 32'hFFFFFFFF);
        step(0, 32'h11C, 0, 0, 0, 0);

        b = edges;
        expect_full(b + 2, "lu_lw_stall", mk(C_LW, 0, 0, 0, 32'h200, 1, 2, 0, 0, 1));
        expect_full(b + 3, "lu_bubble", '0);
        expect_full(b + 4, "lu_add", mk(C_ADD, 0, 0, 32'h1820, 32'h204, 2, 4, 3, 0, 0));
        expect_full(b + 5, "lu_next", mk(C_ADDI, 0, 0, 32'h7, 32'h208, 0, 6, 0, 0, 0));
        step(I_LW2, 32'h200, 0, 0, 0, 0);
        step(I_ADD3, 32'h204, 0, 0, 0, 0);
        step(I_ADDI6, 32'h208, 0, 0, 0, 0);
        step(I_ADDI6, 32'h208, 0, 0, 0, 0);
        step(0, 32'h20C, 0, 0, 0, 0);

        b = edges;
        expect_full(b + 2, "lw0_nostall", mk(C_LW, 0, 0, 0, 32'h300, 1, 0, 0, 0, 0));
        expect_full(b + 3, "lw0_use", mk(C_ADD, 0, 0, 32'h1820, 32'h304, 0, 0, 3, 0, 0));
        step(I_LW0, 32'h300, 0, 0, 0, 0);
        step(I_ADD30, 32'h304, 0, 0, 0, 0);
        step(0, 32'h308, 0, 0, 0, 0);

        b = edges;
        expect_full(b + 2, "flush_sw", '0);
        expect_nop(b + 3, "flush_ifid");
        expect_full(b + 4, "flush_resume", mk(C_ORI, 0, 0, 32'hFFFF, 32'h408, 0, 5, 31, 31, 0));
        step(I_SW, 32'h400, 0, 0, 0, 0);
        step(I_ADDI6, 32'h404, 1, 0, 0, 0);
        step(I_ORI5, 32'h408, 0, 0, 0, 0);
        step(0, 32'h40C, 0, 0, 0, 0);

        b = edges;
        expect_full(b + 2, "fs_lw", mk(C_LW, 0, 0, 0, 32'h500, 1, 2, 0, 0, 1));
        expect_full(b + 3, "fs_bubble", '0);
        expect_nop(b + 4, "fs_ifid_clear");
        expect_full(b + 5, "fs_resume", mk(C_ADDI, 0, 0, 32'h7, 32'h50C, 0, 6, 0, 0, 0));
        step(I_LW2, 32'h500, 0, 0, 0, 0);
        step(I_ADD3, 32'h504, 0, 0, 0, 0);
        step(I_ORI5, 32'h508, 1, 0, 0, 0);
        step(I_ADDI6, 32'h50C, 0, 0, 0, 0);
        step(0, 32'h510, 0, 0, 0, 0);

        b = edges;
        expect_full(b + 2, "rst_pre_rd5", mk(C_ORI, 0, 32'hDEADBEEF, 32'hFFFF, 32'h600, 0, 5, 31, 31, 0));
        expect_full(b + 3, "rst_async", '0);
        expect_full(b + 4, "rst_held", '0);
        expect_full(b + 6, "rst_rd5_zero", mk(C_ADD, 0, 0, 32'h3820, 32'h60C, 5, 5, 7, 0, 0));
        step(I_ORI5, 32'h600, 0, 1, 5, 32'hDEADBEEF);
        step(I_LW2, 32'h604, 0, 0, 0, 0);
        step(I_ADD3, 32'h608, 0, 0, 0, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        step(32'h00A53820, 32'h60C, 0, 0, 0, 0);
        step(0, 32'h610, 0, 0, 0, 0);
        step(0, 32'h614, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
